// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared definitions for the sideband message decoder: bit positions of the
// raw 64-bit sideband word, the supported opcode, the decoder FSM state enum,
// the decoded-field struct and a helper that slices a raw word into fields.
// -----------------------------------------------------------------------------
package sb_pkg;

   localparam int SB_WORD_W       = 64;

   // Field bit positions inside the raw sideband word
   localparam int SB_OPC_LSB      = 0;
   localparam int SB_OPC_MSB      = 4;
   localparam int SB_MSGCODE_LSB  = 5;
   localparam int SB_MSGCODE_MSB  = 12;
   localparam int SB_SUBCODE_LSB  = 13;
   localparam int SB_SUBCODE_MSB  = 20;
   localparam int SB_INFO_LSB     = 21;
   localparam int SB_INFO_MSB     = 36;
   localparam int SB_SRCID_LSB    = 37;
   localparam int SB_SRCID_MSB    = 39;
   localparam int SB_DSTID_LSB    = 40;
   localparam int SB_DSTID_MSB    = 42;
   localparam int SB_RSVD_LSB     = 43;
   localparam int SB_RSVD_MSB     = 61;
   localparam int SB_DP_BIT       = 62;
   localparam int SB_CP_BIT       = 63;

   // Only message-without-data is understood by this decoder
   localparam logic [4:0] SB_OP_MSG_NODATA = 5'b10010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_CHECK = 2'd2,
      ST_OUT   = 2'd3
   } sb_state_e;

   // Outcome of checking a captured word, in precedence order
   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_PARITY = 2'd1,
      ERR_OPCODE = 2'd2,
      ERR_DST    = 2'd3
   } sb_err_e;

   typedef struct packed {
      logic [4:0]  opcode;
      logic [7:0]  msgcode;
      logic [7:0]  msgsubcode;
      logic [15:0] msginfo;
      logic [2:0]  srcid;
      logic [2:0]  dstid;
   } sb_fields_t;

   // Reserved bits and the parity bits are deliberately not extracted.
   function automatic sb_fields_t sb_unpack(input logic [SB_WORD_W-1:0] w);
      sb_fields_t f;
      f.opcode     = w[SB_OPC_MSB:SB_OPC_LSB];
      f.msgcode    = w[SB_MSGCODE_MSB:SB_MSGCODE_LSB];
      f.msgsubcode = w[SB_SUBCODE_MSB:SB_SUBCODE_LSB];
      f.msginfo    = w[SB_INFO_MSB:SB_INFO_LSB];
      f.srcid      = w[SB_SRCID_MSB:SB_SRCID_LSB];
      f.dstid      = w[SB_DSTID_MSB:SB_DSTID_LSB];
      return f;
   endfunction

endpackage

// File: rtl/sb_parity_chk.sv
// -----------------------------------------------------------------------------
// sb_parity_chk
// Combinational parity check of one raw sideband word.
//   word_i   : raw 64-bit sideband word
//   cp_ok_o  : 1 when the XOR of all 64 bits is 0 (CP is even parity of [61:0])
//   dp_ok_o  : 1 when the DP bit is 0 (no data payload is ever legal here)
// -----------------------------------------------------------------------------
module sb_parity_chk
   import sb_pkg::*;
(
   input  logic [SB_WORD_W-1:0] word_i,
   output logic                 cp_ok_o,
   output logic                 dp_ok_o
);

   // Reducing across the full word including CP makes a good word XOR to 0.
   assign cp_ok_o = ~(^word_i);
   assign dp_ok_o = ~word_i[SB_DP_BIT];

endmodule

// File: rtl/sb_msg_decoder.sv
// -----------------------------------------------------------------------------
// sb_msg_decoder
// Pulls raw sideband words from SB_RX, checks parity / opcode / destination and
// presents decoded message fields to the downstream consumer with a
// valid/ready handshake.
//
// Ports
//   clk_100MHz     message-layer clock
//   reset          asynchronous, active-high
//   enable_i       decoder enable (gates new requests only)
//   rx_data_i      raw word from SB_RX
//   rx_valid_i     SB_RX word available
//   msg_req_o      request to SB_RX, high exactly while waiting for a word
//   msg_valid_o    decoded message valid
//   msg_ready_i    downstream accepts the decoded message
//   opcode_o .. srcid_o   decoded fields, stable while msg_valid_o is high
//   parity_err_o / opcode_err_o / dst_err_o   one-cycle error pulses
//   msg_count_o    delivered messages (saturating)
//   err_count_o    rejected words (saturating)
// -----------------------------------------------------------------------------
module sb_msg_decoder
   import sb_pkg::*;
#(
   parameter logic [2:0] OWN_ID = 3'd0
) (
   input  logic                 clk_100MHz,
   input  logic                 reset,
   input  logic                 enable_i,
   input  logic [SB_WORD_W-1:0] rx_data_i,
   input  logic                 rx_valid_i,
   output logic                 msg_req_o,
   output logic                 msg_valid_o,
   input  logic                 msg_ready_i,
   output logic [4:0]           opcode_o,
   output logic [7:0]           msgcode_o,
   output logic [7:0]           msgsubcode_o,
   output logic [15:0]          msginfo_o,
   output logic [2:0]           srcid_o,
   output logic                 parity_err_o,
   output logic                 opcode_err_o,
   output logic                 dst_err_o,
   output logic [15:0]          msg_count_o,
   output logic [7:0]           err_count_o
);

   sb_state_e            state_q, state_d;
   logic [SB_WORD_W-1:0] word_q;
   sb_fields_t           fld;
   sb_err_e              err_sel;
   logic                 cp_ok, dp_ok;
   logic                 xfer;
   logic                 deliver;

   // ---------------------------------------------------------------------------
   // Word checking on the captured word
   // ---------------------------------------------------------------------------
   sb_parity_chk u_parity_chk (
      .word_i  (word_q),
      .cp_ok_o (cp_ok),
      .dp_ok_o (dp_ok)
   );

   assign fld = sb_unpack(word_q);

   // A set DP bit is treated as a parity failure, so parity outranks the rest.
   always_comb begin
      err_sel = ERR_NONE;
      if (!cp_ok || !dp_ok)
         err_sel = ERR_PARITY;
      else if (fld.opcode != SB_OP_MSG_NODATA)
         err_sel = ERR_OPCODE;
      else if (fld.dstid != OWN_ID)
         err_sel = ERR_DST;
   end

   assign xfer    = (state_q == ST_REQ) && rx_valid_i;
   assign deliver = (state_q == ST_OUT) && msg_ready_i;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Every path back to REQ goes through IDLE, which guarantees msg_req_o
   // drops for at least one cycle between transfers.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable_i) state_d = ST_REQ;
         ST_REQ: begin
            if (rx_valid_i)     state_d = ST_CHECK;
            else if (!enable_i) state_d = ST_IDLE;
         end
         ST_CHECK: state_d = (err_sel == ERR_NONE) ? ST_OUT : ST_IDLE;
         // Disabling does not abort a message already offered downstream.
         ST_OUT:   if (msg_ready_i) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign msg_req_o   = (state_q == ST_REQ);
   assign msg_valid_o = (state_q == ST_OUT);

   // ---------------------------------------------------------------------------
   // Capture register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset)     word_q <= '0;
      else if (xfer) word_q <= rx_data_i;
   end

   // ---------------------------------------------------------------------------
   // Decoded field outputs: loaded only for good words, held through OUT
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         opcode_o     <= '0;
         msgcode_o    <= '0;
         msgsubcode_o <= '0;
         msginfo_o    <= '0;
         srcid_o      <= '0;
      end else if (state_q == ST_CHECK && err_sel == ERR_NONE) begin
         opcode_o     <= fld.opcode;
         msgcode_o    <= fld.msgcode;
         msgsubcode_o <= fld.msgsubcode;
         msginfo_o    <= fld.msginfo;
         srcid_o      <= fld.srcid;
      end
   end

   // ---------------------------------------------------------------------------
   // Error pulses: exactly one per rejected word, one cycle wide
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         parity_err_o <= 1'b0;
         opcode_err_o <= 1'b0;
         dst_err_o    <= 1'b0;
      end else begin
         parity_err_o <= (state_q == ST_CHECK) && (err_sel == ERR_PARITY);
         opcode_err_o <= (state_q == ST_CHECK) && (err_sel == ERR_OPCODE);
         dst_err_o    <= (state_q == ST_CHECK) && (err_sel == ERR_DST);
      end
   end

   // ---------------------------------------------------------------------------
   // Saturating counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset)
         msg_count_o <= '0;
      else if (deliver && msg_count_o != 16'hFFFF)
         msg_count_o <= msg_count_o + 16'd1;
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset)
         err_count_o <= '0;
      else if (state_q == ST_CHECK && err_sel != ERR_NONE && err_count_o != 8'hFF)
         err_count_o <= err_count_o + 8'd1;
   end

endmodule

// File: tb/tb_sb_msg_decoder.sv
module tb_sb_msg_decoder;

   localparam logic [2:0] OWN = 3'd0;
   localparam logic [4:0] OP_OK  = 5'b10010;
   localparam logic [4:0] OP_BAD = 5'b11011;

   logic        clk_100MHz = 1'b0;
   logic        reset = 1'b1;
   logic        enable_i = 1'b0;
   logic [63:0] rx_data_i = '0;
   logic        rx_valid_i = 1'b0;
   logic        msg_ready_i = 1'b0;
   logic        msg_req_o, msg_valid_o;
   logic [4:0]  opcode_o;
   logic [7:0]  msgcode_o, msgsubcode_o;
   logic [15:0] msginfo_o;
   logic [2:0]  srcid_o;
   logic        parity_err_o, opcode_err_o, dst_err_o;
   logic [15:0] msg_count_o;
   logic [7:0]  err_count_o;

   int checks = 0;
   int failures = 0;

   sb_msg_decoder #(.OWN_ID(OWN)) dut (
      .clk_100MHz   (clk_100MHz),
      .reset        (reset),
      .enable_i     (enable_i),
      .rx_data_i    (rx_data_i),
      .rx_valid_i   (rx_valid_i),
      .msg_req_o    (msg_req_o),
      .msg_valid_o  (msg_valid_o),
      .msg_ready_i  (msg_ready_i),
      .opcode_o     (opcode_o),
      .msgcode_o    (msgcode_o),
      .msgsubcode_o (msgsubcode_o),
      .msginfo_o    (msginfo_o),
      .srcid_o      (srcid_o),
      .parity_err_o (parity_err_o),
      .opcode_err_o (opcode_err_o),
      .dst_err_o    (dst_err_o),
      .msg_count_o  (msg_count_o),
      .err_count_o  (err_count_o)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Build a raw word; CP is made correct unless bad_cp is set.
   function automatic logic [63:0] mkword(input logic [4:0] op, input logic [7:0] mc,
                                          input logic [7:0] sc, input logic [15:0] info,
                                          input logic [2:0] src, input logic [2:0] dst,
                                          input logic [18:0] rsv, input logic dp,
                                          input logic bad_cp);
      logic [63:0] w;
      w = '0;
      w[4:0]   = op;
      w[12:5]  = mc;
      w[20:13] = sc;
      w[36:21] = info;
      w[39:37] = src;
      w[42:40] = dst;
      w[61:43] = rsv;
      w[62]    = dp;
      w[63]    = (^w[61:0]) ^ bad_cp;
      return w;
   endfunction

   // 0 good, 1 parity, 2 opcode, 3 destination
   function automatic int classify(input logic [63:0] w);
      if ((^w) != 1'b0 || w[62]) return 1;
      if (w[4:0] != OP_OK)       return 2;
      if (w[42:40] != OWN)       return 3;
      return 0;
   endfunction

   // ---------------------------------------------------------------------------
   // Transaction-level model and per-cycle compare
   // ---------------------------------------------------------------------------
   initial begin
      logic        pend;
      logic [63:0] cap;
      logic        exp_valid;
      logic [63:0] exp_w;
      logic [2:0]  exp_pulse;   // {parity, opcode, dst}
      int          exp_mc, exp_ec, c;
      pend = 0; cap = '0; exp_valid = 0; exp_w = '0; exp_pulse = '0; exp_mc = 0; exp_ec = 0;
      forever begin
         @(negedge clk_100MHz);
         if (reset) begin
            chk("rst_req", msg_req_o, 0);
            chk("rst_valid", msg_valid_o, 0);
            chk("rst_fields", {opcode_o, msgcode_o, msgsubcode_o, msginfo_o, srcid_o}, 0);
            chk("rst_pulses", {parity_err_o, opcode_err_o, dst_err_o}, 0);
            chk("rst_counts", {msg_count_o, err_count_o}, 0);
            pend = 0; exp_valid = 0; exp_pulse = '0; exp_mc = 0; exp_ec = 0;
         end else begin
            chk("m_valid", msg_valid_o, exp_valid);
            if (exp_valid) begin
               chk("m_opcode", opcode_o, exp_w[4:0]);
               chk("m_msgcode", msgcode_o, exp_w[12:5]);
               chk("m_subcode", msgsubcode_o, exp_w[20:13]);
               chk("m_msginfo", msginfo_o, exp_w[36:21]);
               chk("m_srcid", srcid_o, exp_w[39:37]);
            end
            chk("m_pulses", {parity_err_o, opcode_err_o, dst_err_o}, exp_pulse);
            chk("m_msg_count", msg_count_o, exp_mc);
            chk("m_err_count", err_count_o, exp_ec);
            if (exp_valid || pend || exp_pulse != 0) chk("m_req_low", msg_req_o, 0);
            // advance model across the coming edge
            exp_pulse = '0;
            if (pend) begin
               c = classify(cap);
               if (c != 0) begin
                  exp_pulse = 3'b100 >> (c - 1);
                  if (exp_ec < 255) exp_ec++;
               end else begin
                  exp_valid = 1;
                  exp_w = cap;
               end
               pend = 0;
            end else if (exp_valid && msg_ready_i) begin
               exp_valid = 0;
               if (exp_mc < 65535) exp_mc++;
            end
            if (msg_req_o && rx_valid_i) begin
               pend = 1;
               cap = rx_data_i;
            end
         end
      end
   end

   // Offer a word until SB_RX-side handshake takes it; returns #1 after the
   // transfer edge (decoder now checking the word).
   task automatic send_word(input logic [63:0] w);
      int n;
      n = 0;
      @(posedge clk_100MHz); #1;
      rx_valid_i = 1'b1;
      rx_data_i  = w;
      forever begin
         @(negedge clk_100MHz);
         if (msg_req_o) break;
         n++;
         if (n > 50) begin
            chk("req_timeout", msg_req_o, 1);
            break;
         end
      end
      @(posedge clk_100MHz); #1;
      rx_valid_i = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk_100MHz);
      #1;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog t=%0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] good, w;
      good = mkword(OP_OK, 8'h95, 8'h01, 16'hBEEF, 3'd2, OWN, 19'h0, 1'b0, 1'b0);

      idle_cycles(3);
      chk("rst_hold_count", msg_count_o, 0);
      reset = 1'b0;
      enable_i = 1'b1;
      msg_ready_i = 1'b1;

      // Good word: latency and literal fields
      send_word(good);
      @(negedge clk_100MHz); chk("lat1_valid", msg_valid_o, 0);
      @(negedge clk_100MHz); chk("lat2_valid", msg_valid_o, 1);
      chk("lit_opcode", opcode_o, 5'b10010);
      chk("lit_msgcode", msgcode_o, 8'h95);
      chk("lit_subcode", msgsubcode_o, 8'h01);
      chk("lit_msginfo", msginfo_o, 16'hBEEF);
      chk("lit_srcid", srcid_o, 3'd2);
      @(negedge clk_100MHz); chk("lit_count1", msg_count_o, 1);

      // CP flipped
      w = good ^ 64'h8000_0000_0000_0000;
      send_word(w);
      @(negedge clk_100MHz); chk("par_chk_cycle", parity_err_o, 0);
      @(negedge clk_100MHz);
      chk("par_pulse", parity_err_o, 1);
      chk("par_req_low", msg_req_o, 0);
      chk("par_valid", msg_valid_o, 0);
      @(negedge clk_100MHz);
      chk("par_pulse_end", parity_err_o, 0);
      chk("par_req_again", msg_req_o, 1);
      chk("par_errcnt", err_count_o, 1);

      // Opcode, destination, combined, DP cases
      send_word(mkword(OP_BAD, 8'h11, 8'h22, 16'h3344, 3'd1, OWN, 19'h0, 1'b0, 1'b0));
      idle_cycles(1); @(negedge clk_100MHz); chk("op_pulse", opcode_err_o, 1);
      send_word(mkword(OP_OK, 8'h11, 8'h22, 16'h3344, 3'd1, 3'd5, 19'h0, 1'b0, 1'b0));
      idle_cycles(1); @(negedge clk_100MHz); chk("dst_pulse", dst_err_o, 1);
      send_word(mkword(OP_BAD, 8'h11, 8'h22, 16'h3344, 3'd1, 3'd5, 19'h0, 1'b0, 1'b1));
      idle_cycles(1); @(negedge clk_100MHz);
      chk("opbad_cp_pulses", {parity_err_o, opcode_err_o, dst_err_o}, 3'b100);
      send_word(mkword(OP_OK, 8'h11, 8'h22, 16'h3344, 3'd1, OWN, 19'h0, 1'b1, 1'b0));
      idle_cycles(1); @(negedge clk_100MHz); chk("dp_pulse", parity_err_o, 1);
      idle_cycles(2);
      chk("errcnt5", err_count_o, 5);

      // Reserved bits ignored
      send_word(mkword(OP_OK, 8'hA0, 8'h0B, 16'hC0DE, 3'd3, OWN, 19'h5A5A5, 1'b0, 1'b0));
      idle_cycles(4);
      chk("rsvd_count", msg_count_o, 2);

      // Disable while waiting: request withdrawn
      enable_i = 1'b0;
      idle_cycles(3);
      chk("disable_req", msg_req_o, 0);
      enable_i = 1'b1;

      // Backpressure; disabling during OUT does not abort
      msg_ready_i = 1'b0;
      send_word(mkword(OP_OK, 8'h3C, 8'h7E, 16'h1234, 3'd7, OWN, 19'h0, 1'b0, 1'b0));
      enable_i = 1'b0;
      @(negedge clk_100MHz);
      repeat (10) begin
         @(negedge clk_100MHz);
         chk("bp_valid", msg_valid_o, 1);
         chk("bp_msgcode", msgcode_o, 8'h3C);
         chk("bp_req", msg_req_o, 0);
      end
      @(posedge clk_100MHz); #1;
      msg_ready_i = 1'b1;
      @(posedge clk_100MHz); @(negedge clk_100MHz);
      chk("bp_count", msg_count_o, 3);
      chk("bp_valid_drop", msg_valid_o, 0);
      enable_i = 1'b1;

      // Three back-to-back good words
      for (int i = 0; i < 3; i++)
         send_word(mkword(OP_OK, 8'(8'h40 + i), 8'(i), 16'($urandom), 3'(i), OWN,
                          19'($urandom), 1'b0, 1'b0));
      idle_cycles(4);
      chk("b2b_count", msg_count_o, 6);
      chk("b2b_errs", err_count_o, 5);

      // Reset while in OUT
      msg_ready_i = 1'b0;
      send_word(good);
      @(negedge clk_100MHz); @(negedge clk_100MHz);
      chk("pre_rst_valid", msg_valid_o, 1);
      @(posedge clk_100MHz); #1;
      reset = 1'b1;
      #1;
      chk("rst_out_valid", msg_valid_o, 0);
      chk("rst_out_mcnt", msg_count_o, 0);
      chk("rst_out_ecnt", err_count_o, 0);
      @(posedge clk_100MHz); #1;
      reset = 1'b0;
      msg_ready_i = 1'b1;
      send_word(good);
      idle_cycles(4);
      chk("post_rst_count", msg_count_o, 1);

      // Error counter saturation
      for (int i = 0; i < 260; i++)
         send_word(mkword(OP_BAD, 8'(i), 8'h00, 16'h0000, 3'd0, OWN, 19'h0, 1'b0, 1'b0));
      idle_cycles(3);
      chk("err_sat", err_count_o, 8'hFF);
      chk("sat_msgcnt", msg_count_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sb_msg_decoder.md
SB_MSG_DECODER -- requirements
Module: sb_msg_decoder

Interface
REQ-001 Parameter OWN_ID, 3'd0, die ID this decoder accepts in dstid field.
REQ-002 clk_100MHz  input  1  message-layer clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clock clk_100MHz.
REQ-004 enable_i  input  1  decoder enable.
REQ-005 rx_data_i  input  64  raw sideband word from SB_RX data_o.
REQ-006 rx_valid_i  input  1  SB_RX valid_o, word available.
REQ-007 msg_req_o  output  1  request to SB_RX (drives its msg_req_i).
REQ-008 msg_valid_o  output  1  decoded message valid.
REQ-009 msg_ready_i  input  1  downstream accepts decoded message.
REQ-010 opcode_o 5, msgcode_o 8, msgsubcode_o 8, msginfo_o 16, srcid_o 3  outputs  decoded fields, stable while msg_valid_o high.
REQ-011 parity_err_o, opcode_err_o, dst_err_o  outputs  1  single-cycle error pulses.
REQ-012 msg_count_o  output  16  delivered-message count; err_count_o  output  8  error count.

Function
REQ-013 Word format SHALL be: [4:0] opcode, [12:5] msgcode, [20:13] msgsubcode, [36:21] msginfo, [39:37] srcid, [42:40] dstid, [61:43] reserved, [62] DP, [63] CP.
REQ-014 CP SHALL be even parity over [61:0] (XOR of [63:0] equals 0 for a good word); DP SHALL be 0.
REQ-015 Only opcode 5'b10010 (message without data) SHALL be supported; any other opcode is an opcode error.
REQ-016 FSM states SHALL be IDLE, REQ, CHECK, OUT.
REQ-017 IDLE -> REQ when enable_i=1; otherwise stay IDLE.
REQ-018 msg_req_o SHALL be 1 exactly when state=REQ.
REQ-019 Transfer SHALL occur on an edge with state=REQ and rx_valid_i=1: word captured, state -> CHECK.
REQ-020 REQ -> IDLE when enable_i=0 and no transfer on that edge.
REQ-021 CHECK SHALL evaluate errors with precedence parity > opcode > dst (dstid != OWN_ID, or DP=1 counts as parity); exactly one pulse per bad word.
REQ-022 CHECK with error: pulse the selected *_err_o for one cycle, err_count_o +1, word dropped, state -> IDLE.
REQ-023 CHECK without error: fields registered, msg_valid_o=1, state -> OUT; latency transfer edge to msg_valid_o high is 2 cycles.
REQ-024 OUT: hold msg_valid_o and fields until msg_valid_o && msg_ready_i, then msg_valid_o=0, msg_count_o +1, state -> IDLE; enable_i=0 does not abort OUT.
REQ-025 msg_req_o SHALL be low at least one cycle between consecutive transfers (via IDLE).
REQ-026 msg_count_o saturates at 16'hFFFF; err_count_o saturates at 8'hFF; no wrap.
REQ-027 Reserved bits [61:43] SHALL be ignored except for parity.

Reset
REQ-028 On reset: state IDLE, msg_req_o=0, msg_valid_o=0, all fields 0, all error pulses 0, both counters 0.
REQ-029 Reset mid-message (REQ/CHECK/OUT) SHALL discard the captured word with no pulse and no count change beyond clearing.

Structure
REQ-030 Shared package sb_pkg SHALL hold field bit-position constants, opcode constant SB_OP_MSG_NODATA=5'b10010, and the FSM state enum.
REQ-031 One sub-module sb_parity_chk (combinational 64-bit XOR reduce, outputs CP-ok and DP-ok) SHALL be instantiated.

Verification
REQ-032 Good word: opcode 10010, msgcode 8'h95, subcode 8'h01, msginfo 16'hBEEF, srcid 3'd2, dstid 0, correct CP -> msg_valid_o 2 cycles after transfer with those fields; msg_count_o=1.
REQ-033 Same word with bit 63 flipped -> parity_err_o one-cycle pulse, no msg_valid_o, err_count_o=1, msg_req_o reasserted after one low cycle.
REQ-034 Opcode 5'b11011 with correct CP -> opcode_err_o pulse only; dstid 3'd5 with correct CP -> dst_err_o pulse only; opcode 11011 plus bad CP -> parity_err_o only.
REQ-035 Backpressure: msg_ready_i=0 for 10 cycles -> fields stable, msg_req_o=0 throughout; ready=1 -> one delivery, count +1.
REQ-036 Three back-to-back good words via SB_TX/SB_RX chain -> delivered in order, msg_count_o=3, err_count_o=0.
REQ-037 Reset asserted while in OUT -> msg_valid_o=0 and counters 0 immediately; after release, next good word decoded normally.
